// File: rtl/riscv_opcodes_pkg.sv
// rtl/riscv_opcodes_pkg.sv - shared register-file types and defaults
//  RF_XLEN / RF_NREGS : default data width and architectural register count
//  rsd_t              : register specifier for the 32-register view
//  rf_state_e         : register-file sequencer state
package riscv_opcodes_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef logic [4:0] rsd_t;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/riscv_rf_rdport.sv
// rtl/riscv_rf_rdport.sv - one synchronous read port: address reg, x0 mask, bypass mux, data reg
//  clk, rst      : clock, synchronous active-high reset
//  pd_stall_i    : hold the sampled address
//  id_stall_i    : hold the read data output
//  src_i         : read address from PD
//  addr_q_o      : sampled address (top uses it to index storage)
//  rf_data_i     : storage contents at addr_q_o
//  wr_commit_i   : per write port, write actually commits this cycle
//  wr_dst_i      : packed write addresses
//  wr_data_i     : packed write data
//  q_o           : read data to ID
module riscv_rf_rdport
  import riscv_opcodes_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int AW     = 5,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pd_stall_i,
  input  logic                   id_stall_i,
  input  logic [AW-1:0]          src_i,
  output logic [AW-1:0]          addr_q_o,
  input  logic [XLEN-1:0]        rf_data_i,
  input  logic [NUM_WR-1:0]      wr_commit_i,
  input  logic [NUM_WR*AW-1:0]   wr_dst_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0]        q_o
);

  logic [XLEN-1:0] q_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q_o <= '0;
    end else if (!pd_stall_i) begin
      addr_q_o <= src_i;
    end
  end

  // Later write ports overwrite earlier hits so the collision winner is forwarded.
  // The x0 mask is applied last so nothing can leak a nonzero x0.
  always_comb begin
    q_nxt = rf_data_i;
    for (int w = 0; w < NUM_WR; w++) begin
      if (BYPASS != 0 && wr_commit_i[w] && wr_dst_i[w*AW +: AW] == addr_q_o) begin
        q_nxt = wr_data_i[w*XLEN +: XLEN];
      end
    end
    if (addr_q_o == '0) begin
      q_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else if (!id_stall_i) begin
      q_o <= q_nxt;
    end
  end

endmodule

// File: rtl/riscv_rf_mp.sv
// rtl/riscv_rf_mp.sv - multi-port integer register file with x0=0, bypass and post-reset clear
//  clk, rst      : clock, synchronous active-high reset
//  pd_stall_i    : PD stall, holds sampled read addresses
//  id_stall_i    : ID stall, holds read data outputs
//  rf_src_i      : NUM_RD packed read addresses
//  rf_src_q_o    : NUM_RD packed read data
//  rf_dst_i      : NUM_WR packed write addresses
//  rf_dst_d_i    : NUM_WR packed write data
//  rf_we_i       : NUM_WR write enables
//  rf_busy_o     : clear sequence running, pipeline must stall
module riscv_rf_mp
  import riscv_opcodes_pkg::*;
#(
  parameter int XLEN      = RF_XLEN,
  parameter int NREGS     = RF_NREGS,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int BYPASS    = 1,
  parameter int CLEAR_RST = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pd_stall_i,
  input  logic                   id_stall_i,
  input  logic [NUM_RD*AW-1:0]   rf_src_i,
  output logic [NUM_RD*XLEN-1:0] rf_src_q_o,
  input  logic [NUM_WR*AW-1:0]   rf_dst_i,
  input  logic [NUM_WR*XLEN-1:0] rf_dst_d_i,
  input  logic [NUM_WR-1:0]      rf_we_i,
  output logic                   rf_busy_o
);

  logic [XLEN-1:0]   rf [NREGS];
  rf_state_e         state;
  rf_state_e         state_nxt;
  logic [AW-1:0]     cnt;
  logic [NUM_WR-1:0] commit;

  // Clear sequencer: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_RST != 0) ? RF_CLEAR : RF_IDLE;
      cnt   <= AW'(1);
    end else begin
      state <= state_nxt;
      if (state == RF_CLEAR) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // Clear sequencer: next state
  always_comb begin
    state_nxt = state;
    if (state == RF_CLEAR && cnt == AW'(NREGS - 1)) begin
      state_nxt = RF_IDLE;
    end
  end

  // Clear sequencer: outputs
  always_comb begin
    rf_busy_o = (state == RF_CLEAR);
  end

  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      commit[w] = rf_we_i[w] & ~pd_stall_i & ~id_stall_i & ~rf_busy_o
                & (rf_dst_i[w*AW +: AW] != '0);
    end
  end

  // Storage is deliberately not reset; the clear sequencer zeroes it instead.
  // Iterating w upward lets the highest-index port win a same-address collision.
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      rf[cnt] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (commit[w]) begin
          rf[rf_dst_i[w*AW +: AW]] <= rf_dst_d_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] addr_q;

    riscv_rf_rdport #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NUM_WR (NUM_WR),
      .BYPASS (BYPASS)
    ) u_rdport (
      .clk         (clk),
      .rst         (rst),
      .pd_stall_i  (pd_stall_i),
      .id_stall_i  (id_stall_i),
      .src_i       (rf_src_i[p*AW +: AW]),
      .addr_q_o    (addr_q),
      .rf_data_i   (rf[addr_q]),
      .wr_commit_i (commit),
      .wr_dst_i    (rf_dst_i),
      .wr_data_i   (rf_dst_d_i),
      .q_o         (rf_src_q_o[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_riscv_rf_mp.sv
// tb/tb_riscv_rf_mp.sv - self-checking bench for riscv_rf_mp against a behavioural model
module tb_riscv_rf_mp;

  localparam int NR = 2;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          pd;
  logic          id;
  logic [NR*5-1:0]  src;
  logic [NR*32-1:0] q;
  logic [NW*5-1:0]  dst;
  logic [NW*32-1:0] wd;
  logic [NW-1:0]    we;
  logic          busy;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  riscv_rf_mp #(
    .XLEN(32), .NREGS(32), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .CLEAR_RST(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pd_stall_i (pd),
    .id_stall_i (id),
    .rf_src_i   (src),
    .rf_src_q_o (q),
    .rf_dst_i   (dst),
    .rf_dst_d_i (wd),
    .rf_we_i    (we),
    .rf_busy_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents with a known/unknown flag, plus the
  // address and data each port currently holds.
  logic [31:0] mmem [32];
  bit          mv   [32];
  int          brem;
  logic [4:0]  maq  [NR];
  logic [31:0] mq   [NR];
  bit          mqv  [NR];
  bit          ok;
  bit          hit;
  logic [31:0] bv;
  logic [4:0]  a;

  initial begin
    for (int r = 0; r < 32; r++) begin
      mmem[r] = '0;
      mv[r]   = 0;
    end
    brem = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      brem = 31;
      for (int p = 0; p < NR; p++) begin
        maq[p] = '0; mq[p] = '0; mqv[p] = 1;
      end
      for (int r = 0; r < 32; r++) mv[r] = 0;
    end else begin
      ok = !pd && !id && (brem == 0);
      if (!id) begin
        for (int p = 0; p < NR; p++) begin
          a = maq[p];
          if (a == 0) begin
            mq[p] = '0; mqv[p] = 1;
          end else begin
            hit = 0; bv = '0;
            for (int w = 0; w < NW; w++) begin
              if (ok && we[w] && dst[w*5 +: 5] == a) begin
                hit = 1; bv = wd[w*32 +: 32];
              end
            end
            if (hit) begin
              mq[p] = bv; mqv[p] = 1;
            end else begin
              mq[p] = mmem[a]; mqv[p] = mv[a];
            end
          end
        end
      end
      if (brem > 0) begin
        mmem[32 - brem] = '0;
        mv[32 - brem]   = 1;
        brem--;
      end else if (ok) begin
        for (int w = 0; w < NW; w++) begin
          if (we[w] && dst[w*5 +: 5] != 0) begin
            mmem[dst[w*5 +: 5]] = wd[w*32 +: 32];
            mv[dst[w*5 +: 5]]   = 1;
          end
        end
      end
      if (!pd) begin
        for (int p = 0; p < NR; p++) maq[p] = src[p*5 +: 5];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_busy", {31'b0, busy}, {31'b0, brem > 0});
      for (int p = 0; p < NR; p++) begin
        if (mqv[p]) chk($sformatf("model_q%0d", p), q[p*32 +: 32], mq[p]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pd = 0; id = 0; we = '0; dst = '0; wd = '0; src = '0;
  endtask

  task automatic wait_busy_len(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk(name, n, 31);
  endtask

  initial begin
    rst = 1;
    idle_in();
    step();
    started = 1;
    step();
    chk("reset_q0", q[31:0], 32'h0);
    chk("reset_q1", q[63:32], 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h1);

    // 1: clear sequence length, then every register reads zero
    rst = 0;
    wait_busy_len("busy_len");
    for (int k = 1; k < 32; k++) begin
      src[4:0] = 5'(k);
      step();
      step();
      chk("cleared_reg", q[31:0], 32'h0);
    end

    // 2: write x5, read on port 1
    idle_in();
    we[0] = 1; dst[4:0] = 5'd5; wd[31:0] = 32'hDEAD_BEEF;
    step();
    we = '0; src[9:5] = 5'd5;
    step();
    step();
    chk("x5_read", q[63:32], 32'hDEAD_BEEF);

    // 3: x0 writes dropped, x0 bypass masked
    we[0] = 1; dst[4:0] = 5'd0; wd[31:0] = 32'h1234;
    step();
    we = '0; src = '0;
    step();
    step();
    chk("x0_p0", q[31:0], 32'h0);
    chk("x0_p1", q[63:32], 32'h0);
    we = 2'b11; dst = {5'd0, 5'd0}; wd = {32'h5678, 32'h9999};
    step();
    chk("x0_byp", q[31:0], 32'h0);

    // 4: two-port collision, higher port wins
    we = 2'b01; dst = {5'd0, 5'd8}; wd = {32'h0, 32'h55};
    step();
    we = 2'b11; dst = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
    step();
    we = '0; src = {5'd8, 5'd7};
    step();
    step();
    chk("collide_x7", q[31:0], 32'h22);
    chk("keep_x8", q[63:32], 32'h55);

    // 5: id stall holds data; same-cycle bypass
    we = 2'b01; dst = {5'd0, 5'd3}; wd = {32'h0, 32'h33}; src = {5'd0, 5'd3};
    step();
    we = '0;
    step();
    chk("x3_plain", q[31:0], 32'h33);
    we = 2'b01; wd[31:0] = 32'h44;
    step();
    chk("x3_byp44", q[31:0], 32'h44);
    id = 1; wd[31:0] = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("x3_hold", q[31:0], 32'h44);
    end
    id = 0; wd[31:0] = 32'hAA;
    step();
    chk("x3_bypAA", q[31:0], 32'hAA);

    // 6: reset in the middle of clear restarts it; writes dropped meanwhile
    idle_in();
    rst = 1;
    step();
    rst = 0;
    we = 2'b01; dst = {5'd0, 5'd9}; wd = {32'h0, 32'hCAFE};
    for (int i = 0; i < 10; i++) step();
    chk("mid_busy", {31'b0, busy}, 32'h1);
    rst = 1;
    step();
    rst = 0;
    wait_busy_len("busy_restart");
    we = '0; src = {5'd0, 5'd9};
    step();
    step();
    chk("x9_cleared", q[31:0], 32'h0);

    // Randomized traffic checked by the model on every cycle
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      pd  = ($urandom_range(0, 3) == 0);
      id  = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < NR; p++) src[p*5 +: 5] = 5'($urandom_range(0, 31));
      for (int w = 0; w < NW; w++) begin
        we[w] = ($urandom_range(0, 1) == 1);
        dst[w*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                     : 5'($urandom_range(0, 31));
        wd[w*32 +: 32] = $urandom;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
